hmac_tag_append: RTL and testbench
==================================

HMAC_TAG_APPEND -- requirements
Module: hmac_tag_append

Interface
REQ-001 Parameter: DATA_W, default 512, stream data width in bits.
REQ-002 Parameter: ID_W, default 6, tid width in bits.
REQ-003 Parameter: TIMEOUT, default 4096, maximum cycles to wait for a digest.
REQ-004 aclk  in  1  sole clock; all logic is rising-edge.
REQ-005 areset  in  1  synchronous, active-high reset.
REQ-006 s_axis_tvalid/tready/tdata/tkeep/tid/tlast  in/out/in/in/in/in  1/1/DATA_W/DATA_W/8/ID_W/1  payload packet input.
REQ-007 m_axis_tvalid/tready/tdata/tkeep/tid/tlast  out/in/out/out/out/out  same widths  tagged packet output, toward the network.
REQ-008 m_hash_tvalid/tready/tdata/tkeep/tid/tlast  out/in/out/out/out/out  same widths  payload copy sent to the external HMAC engine.
REQ-009 s_dig_tvalid/tready/tdata  in/out/in  1/1/DATA_W  digest returned by the HMAC engine.
REQ-010 pkt_count  out  32  number of tag beats emitted, wrapping.
REQ-011 timeout_err  out  1  sticky flag, set on a digest timeout.

Function
REQ-012 The FSM SHALL have three states: PAYLOAD (reset state), WAIT_DIG, EMIT_TAG.
REQ-013 In PAYLOAD, s_axis_tready SHALL equal m_axis_tready AND m_hash_tready.
- m_axis_tvalid SHALL equal s_axis_tvalid AND m_hash_tready.
- m_hash_tvalid SHALL equal s_axis_tvalid AND m_axis_tready.
- A beat is consumed only when it transfers on both outputs in the same cycle.
REQ-014 Payload tdata, tkeep and tid SHALL pass combinationally to both outputs with zero latency.
REQ-015 m_hash_tlast SHALL equal s_axis_tlast, and m_axis_tlast SHALL be 0 on every payload beat.
REQ-016 On the accepted payload beat with tlast=1, the block SHALL latch tid, clear the wait counter, and enter WAIT_DIG.
REQ-017 In WAIT_DIG and EMIT_TAG, s_axis_tready, m_hash_tvalid and m_axis_tvalid SHALL be 0, except for the tag beat in EMIT_TAG.
REQ-018 s_dig_tready SHALL be 1 only in WAIT_DIG; a digest offered in any other state SHALL be stalled, never dropped.
REQ-019 On a digest handshake, the block SHALL register the digest and enter EMIT_TAG on the next cycle (one-cycle latency).
REQ-020 The wait counter SHALL increment each cycle in WAIT_DIG.
- At count TIMEOUT-1 with no digest, the block SHALL register an all-zero tag, set timeout_err, and enter EMIT_TAG.
- If a digest and the timeout occur in the same cycle, the digest SHALL win and timeout_err SHALL NOT be set.
REQ-021 In EMIT_TAG, the tag beat SHALL be: m_axis_tvalid=1, tdata=registered tag, tkeep=all ones, tid=latched tid, tlast=1.
- The beat SHALL be held stable until m_axis_tready.
- On the handshake, pkt_count SHALL increment (wrapping 2^32-1 to 0) and the FSM SHALL return to PAYLOAD.
REQ-022 Only one packet SHALL be in flight; the next packet's first beat is not accepted before the cycle after the tag handshake.

Reset
REQ-023 While areset=1, the block SHALL force: state=PAYLOAD, pkt_count=0, timeout_err=0, wait counter=0, tag register=0, and all tvalid/tready outputs low.
REQ-024 Reset mid-packet SHALL abandon the partial packet, with no tag beat emitted for it.
REQ-025 The first beat SHALL be accepted no earlier than the first cycle after areset deasserts.

Structure
REQ-026 The shared package SHALL hold the FSM state enum, the all-ones KEEP constant and the default TIMEOUT.
- DATA_W and ID_W SHALL use the existing shared stream-width constants.
REQ-027 The block SHALL be a single module with no sub-modules.
- The wait-timeout counter may be split out as the sub-module hmac_wait_timer if reused.

Verification
REQ-028 Scenario: 3-beat packet with tid=5, data 0x11/0x22/0x33, digest 0xABCD returned 10 cycles later.
- Response: output is 0x11, 0x22, 0x33 (tlast=0), then 0xABCD with tlast=1, tid=5, keep=all ones.
- Hash port receives the same 3 beats with tlast on the third; pkt_count=1.
REQ-029 Scenario: m_hash_tready=0 for 5 cycles mid-packet.
- Response: no beat on either output during the stall, and no beat duplicated or lost.
REQ-030 Scenario: TIMEOUT=16, digest never returned.
- Response: tag beat 0x0 emitted exactly 16 cycles after the last payload handshake, and timeout_err=1 until reset.
REQ-031 Scenario: digest valid asserted during PAYLOAD.
- Response: s_dig_tready=0, and the digest is accepted in the first WAIT_DIG cycle.
REQ-032 Scenario: areset pulsed after beat 2 of a 4-beat packet.
- Response: all outputs idle, no tag beat, pkt_count=0.
- A following 1-beat packet is tagged normally.
REQ-033 Scenario: m_axis_tready toggled 1/0 each cycle during the tag beat, with pkt_count preset near wrap.
- Response: tag data stays stable while stalled, and pkt_count wraps from 0xFFFFFFFF to 0.

Source files
------------

// File: rtl/hmac_tag_append_pkg.sv
// ---------------------------------------------------------------------------
// hmac_tag_append_pkg
// Shared definitions for the HMAC tag-append block:
//   - stream width constants used across the datapath
//   - FSM state enumeration
//   - all-ones KEEP constant for a full-width tag beat
//   - default digest timeout and counter width helper
// ---------------------------------------------------------------------------
package hmac_tag_append_pkg;

  // Shared stream geometry
  localparam int unsigned STREAM_DATA_W = 512;
  localparam int unsigned STREAM_ID_W   = 6;
  localparam int unsigned STREAM_KEEP_W = STREAM_DATA_W / 8;

  // Maximum number of cycles spent waiting for a digest
  localparam int unsigned DEFAULT_TIMEOUT = 4096;

  // Tag beats always carry a full data word
  localparam logic [STREAM_KEEP_W-1:0] KEEP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_PAYLOAD  = 2'd0,
    ST_WAIT_DIG = 2'd1,
    ST_EMIT_TAG = 2'd2
  } hta_state_e;

  // Counter width able to hold TIMEOUT-1; never narrower than one bit
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage : hmac_tag_append_pkg

// File: rtl/hmac_wait_timer.sv
// ---------------------------------------------------------------------------
// hmac_wait_timer
// Counts cycles spent waiting for a digest and flags the last permitted cycle.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_clear      restart the count from zero
//   i_en         count this cycle (block is waiting)
//   o_expired_c  combinational: waiting and count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module hmac_wait_timer
  import hmac_tag_append_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned      CNT_W    = timer_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Saturate at the last value so a stalled exit can never wrap the count
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_LAST)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired_c = i_en && (r_count == CNT_LAST);

endmodule : hmac_wait_timer

// File: rtl/hmac_tag_append.sv
// ---------------------------------------------------------------------------
// hmac_tag_append
// Forwards each payload packet to the network and, in lock-step, to an
// external HMAC engine. After the last payload beat it waits for the digest
// (or a timeout) and appends it as a single tag beat closing the packet.
// Ports:
//   aclk, areset                 clock and synchronous active-high reset
//   s_axis_*                     payload packet input
//   m_axis_*                     tagged packet output (payload then tag)
//   m_hash_*                     payload copy toward the HMAC engine
//   s_dig_tvalid/tready/tdata    digest returned by the HMAC engine
//   pkt_count                    tag beats emitted, wrapping 32-bit count
//   timeout_err                  sticky, set when a digest wait times out
// ---------------------------------------------------------------------------
module hmac_tag_append
  import hmac_tag_append_pkg::*;
#(
  parameter int unsigned DATA_W  = STREAM_DATA_W,
  parameter int unsigned ID_W    = STREAM_ID_W,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  aclk,
  input  logic                  areset,

  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic [ID_W-1:0]       s_axis_tid,
  input  logic                  s_axis_tlast,

  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic [ID_W-1:0]       m_axis_tid,
  output logic                  m_axis_tlast,

  output logic                  m_hash_tvalid,
  input  logic                  m_hash_tready,
  output logic [DATA_W-1:0]     m_hash_tdata,
  output logic [DATA_W/8-1:0]   m_hash_tkeep,
  output logic [ID_W-1:0]       m_hash_tid,
  output logic                  m_hash_tlast,

  input  logic                  s_dig_tvalid,
  output logic                  s_dig_tready,
  input  logic [DATA_W-1:0]     s_dig_tdata,

  output logic [31:0]           pkt_count,
  output logic                  timeout_err
);

  localparam int unsigned       KEEP_W      = DATA_W / 8;
  localparam logic [1:0]        S_PAYLOAD   = 2'(ST_PAYLOAD);
  localparam logic [1:0]        S_WAIT_DIG  = 2'(ST_WAIT_DIG);
  localparam logic [1:0]        S_EMIT_TAG  = 2'(ST_EMIT_TAG);
  localparam logic [KEEP_W-1:0] TAG_KEEP    = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_tag;
  logic [ID_W-1:0]   r_tid;
  logic [31:0]       r_pkt_count;
  logic              r_timeout_err;

  logic w_in_payload;
  logic w_in_wait;
  logic w_in_emit;
  logic w_pay_fire;
  logic w_pay_last;
  logic w_dig_fire;
  logic w_timer_expired;
  logic w_timeout;
  logic w_tag_fire;

  // State decode; reset forces every handshake signal low
  assign w_in_payload = !areset && (r_state == S_PAYLOAD);
  assign w_in_wait    = !areset && (r_state == S_WAIT_DIG);
  assign w_in_emit    = !areset && (r_state == S_EMIT_TAG);

  // A payload beat moves only when both destinations take it together
  assign w_pay_fire = w_in_payload && s_axis_tvalid && m_axis_tready && m_hash_tready;
  assign w_pay_last = w_pay_fire && s_axis_tlast;
  assign w_dig_fire = w_in_wait && s_dig_tvalid;
  // A digest arriving on the final wait cycle beats the timeout
  assign w_timeout  = w_timer_expired && !s_dig_tvalid;
  assign w_tag_fire = w_in_emit && m_axis_tready;

  hmac_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk       (aclk),
    .i_rst       (areset),
    .i_clear     (w_pay_last),
    .i_en        (w_in_wait),
    .o_expired_c (w_timer_expired)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PAYLOAD: begin
        if (w_pay_last) begin
          w_state_nxt = S_WAIT_DIG;
        end
      end
      S_WAIT_DIG: begin
        if (w_dig_fire || w_timeout) begin
          w_state_nxt = S_EMIT_TAG;
        end
      end
      S_EMIT_TAG: begin
        if (w_tag_fire) begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      default: begin
        w_state_nxt = S_PAYLOAD;
      end
    endcase
  end

  // State register and tag/status bookkeeping
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= S_PAYLOAD;
      r_tag         <= '0;
      r_tid         <= '0;
      r_pkt_count   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pay_last) begin
        r_tid <= s_axis_tid;
      end
      if (w_dig_fire) begin
        r_tag <= s_dig_tdata;
      end else if (w_timeout) begin
        r_tag         <= '0;
        r_timeout_err <= 1'b1;
      end
      if (w_tag_fire) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  // Input and digest handshakes
  assign s_axis_tready = w_in_payload && m_axis_tready && m_hash_tready;
  assign s_dig_tready  = w_in_wait;

  // Network output: payload passes through with tlast cleared, then the tag
  assign m_axis_tvalid = (w_in_payload && s_axis_tvalid && m_hash_tready) || w_in_emit;
  assign m_axis_tdata  = w_in_emit ? r_tag    : s_axis_tdata;
  assign m_axis_tkeep  = w_in_emit ? TAG_KEEP : s_axis_tkeep;
  assign m_axis_tid    = w_in_emit ? r_tid    : s_axis_tid;
  assign m_axis_tlast  = w_in_emit;

  // Hash output: unmodified payload copy
  assign m_hash_tvalid = w_in_payload && s_axis_tvalid && m_axis_tready;
  assign m_hash_tdata  = s_axis_tdata;
  assign m_hash_tkeep  = s_axis_tkeep;
  assign m_hash_tid    = s_axis_tid;
  assign m_hash_tlast  = s_axis_tlast;

  assign pkt_count   = r_pkt_count;
  assign timeout_err = r_timeout_err;

endmodule : hmac_tag_append

// File: tb/tb_hmac_tag_append.sv
// ---------------------------------------------------------------------------
// tb_hmac_tag_append
// Directed and randomized packets against a packet-level reference model:
// expected network stream = payload beats (tlast=0) + one tag beat per packet,
// expected hash stream = payload beats with tlast on the final beat.
// ---------------------------------------------------------------------------
module tb_hmac_tag_append;

  localparam int unsigned DW = 64;
  localparam int unsigned IW = 6;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [IW-1:0] s_axis_tid;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [IW-1:0] m_axis_tid;
  logic          m_hash_tvalid, m_hash_tready, m_hash_tlast;
  logic [DW-1:0] m_hash_tdata;
  logic [KW-1:0] m_hash_tkeep;
  logic [IW-1:0] m_hash_tid;
  logic          s_dig_tvalid, s_dig_tready;
  logic [DW-1:0] s_dig_tdata;
  logic [31:0]   pkt_count;
  logic          timeout_err;

  always #5 aclk = ~aclk;

  hmac_tag_append #(.DATA_W(DW), .ID_W(IW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tid(s_axis_tid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
    .m_hash_tvalid(m_hash_tvalid), .m_hash_tready(m_hash_tready), .m_hash_tdata(m_hash_tdata),
    .m_hash_tkeep(m_hash_tkeep), .m_hash_tid(m_hash_tid), .m_hash_tlast(m_hash_tlast),
    .s_dig_tvalid(s_dig_tvalid), .s_dig_tready(s_dig_tready), .s_dig_tdata(s_dig_tdata),
    .pkt_count(pkt_count), .timeout_err(timeout_err)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned s_hs_cnt = 0, dig_hs_cnt = 0, tag_cnt = 0;
  int unsigned last_pay_cyc = 0, dig_hs_cyc = 0, tag_vis_cyc = 0;
  bit          tag_vis_seen = 1'b0;
  bit          rand_bp = 1'b0;
  logic [31:0] model_count = 32'd0;
  beat_t       exp_m[$], exp_h[$], got_m[$], got_h[$];
  logic [DW-1:0] pkt_data[$];

  function automatic void check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Observe handshakes mid-cycle; each one completes at the following rising edge
  always @(negedge aclk) begin
    if (!areset) begin
      if (s_axis_tvalid && s_axis_tready) s_hs_cnt++;
      if (s_dig_tvalid && s_dig_tready) begin
        dig_hs_cnt++;
        dig_hs_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tlast && !tag_vis_seen) begin
        tag_vis_seen = 1'b1;
        tag_vis_cyc  = cyc;
      end
      if (m_hash_tvalid && m_hash_tready) begin
        got_h.push_back({m_hash_tdata, m_hash_tkeep, m_hash_tid, m_hash_tlast});
        if (m_hash_tlast) last_pay_cyc = cyc;
        check("hash_beat_paired", 128'(m_axis_tvalid && m_axis_tready && !m_axis_tlast), 128'(1));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_m.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast});
        if (m_axis_tlast) tag_cnt++;
        else check("net_beat_paired", 128'(m_hash_tvalid && m_hash_tready), 128'(1));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_bp) begin
      m_axis_tready = ($urandom_range(3) != 0);
      m_hash_tready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic fill_random(input int n);
    pkt_data.delete();
    for (int i = 0; i < n; i++) pkt_data.push_back({$urandom, $urandom});
  endtask

  // Sends the first n_send beats of pkt_data; stall_at holds m_hash_tready low for 5 cycles on that beat
  task automatic send_pkt(input logic [IW-1:0] id, input int stall_at, input int n_send);
    int n;
    n = pkt_data.size();
    for (int b = 0; b < n_send; b++) begin
      int unsigned   start;
      int            budget;
      logic [KW-1:0] k;
      k = KW'($urandom);
      s_axis_tdata = pkt_data[b];
      s_axis_tkeep = k;
      s_axis_tid   = id;
      s_axis_tlast = (b == n - 1);
      exp_m.push_back({pkt_data[b], k, id, 1'b0});
      exp_h.push_back({pkt_data[b], k, id, 1'(b == n - 1)});
      start = s_hs_cnt;
      s_axis_tvalid = 1'b1;
      if (b == stall_at) begin
        int unsigned seen;
        seen = got_m.size() + got_h.size();
        m_hash_tready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_net_valid", 128'(m_axis_tvalid), 128'(0));
          check("stall_s_ready", 128'(s_axis_tready), 128'(0));
        end
        check("stall_no_beats", 128'(got_m.size() + got_h.size()), 128'(seen));
        m_hash_tready = 1'b1;
      end
      budget = 0;
      while (s_hs_cnt == start && budget < 200) begin
        tick();
        budget++;
      end
      check("beat_accepted", 128'(s_hs_cnt != start), 128'(1));
      s_axis_tvalid = 1'b0;
      if (b != n_send - 1 && $urandom_range(3) == 0) tick();
    end
  endtask

  task automatic give_digest(input logic [DW-1:0] d, input int unsigned delay);
    int unsigned start;
    int          budget;
    start  = dig_hs_cnt;
    budget = 0;
    repeat (delay) tick();
    s_dig_tvalid = 1'b1;
    s_dig_tdata  = d;
    while (dig_hs_cnt == start && budget < 100) begin
      tick();
      budget++;
    end
    check("digest_accepted", 128'(dig_hs_cnt != start), 128'(1));
    s_dig_tvalid = 1'b0;
  endtask

  task automatic expect_tag(input logic [IW-1:0] id, input logic [DW-1:0] tag);
    exp_m.push_back({tag, {KW{1'b1}}, id, 1'b1});
    model_count = model_count + 32'd1;
  endtask

  task automatic wait_tag();
    int unsigned start;
    int          budget;
    start  = tag_cnt;
    budget = 0;
    while (tag_cnt == start && budget < 100) begin
      tick();
      budget++;
    end
    check("tag_emitted", 128'(tag_cnt != start), 128'(1));
  endtask

  task automatic compare_streams(input string name);
    check({name, "_net_len"}, 128'(got_m.size()), 128'(exp_m.size()));
    check({name, "_hash_len"}, 128'(got_h.size()), 128'(exp_h.size()));
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
      check({name, "_net_beat"}, 128'(got_m[i]), 128'(exp_m[i]));
    for (int i = 0; i < exp_h.size() && i < got_h.size(); i++)
      check({name, "_hash_beat"}, 128'(got_h[i]), 128'(exp_h[i]));
    exp_m.delete(); exp_h.delete(); got_m.delete(); got_h.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    areset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tid = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; m_hash_tready = 1'b1;
    s_dig_tvalid = 1'b0; s_dig_tdata = '0;
    repeat (3) tick();

    // Reset state, with valid offered on every input
    s_axis_tvalid = 1'b1; s_dig_tvalid = 1'b1;
    #1;
    check("rst_s_ready", 128'(s_axis_tready), 128'(0));
    check("rst_net_valid", 128'(m_axis_tvalid), 128'(0));
    check("rst_hash_valid", 128'(m_hash_tvalid), 128'(0));
    check("rst_dig_ready", 128'(s_dig_tready), 128'(0));
    check("rst_pkt_count", 128'(pkt_count), 128'(0));
    check("rst_timeout_err", 128'(timeout_err), 128'(0));
    s_axis_tvalid = 1'b0; s_dig_tvalid = 1'b0;
    tick();
    areset = 1'b0;
    #1;
    check("post_rst_s_ready", 128'(s_axis_tready), 128'(1));

    // 3-beat packet, tid 5, digest returned 10 cycles into the wait
    pkt_data.delete();
    pkt_data.push_back(64'h11); pkt_data.push_back(64'h22); pkt_data.push_back(64'h33);
    tag_vis_seen = 1'b0;
    send_pkt(6'd5, -1, 3);
    give_digest(64'hABCD, 10);
    check("s28_dig_cycle", 128'(dig_hs_cyc), 128'(last_pay_cyc + 11));
    expect_tag(6'd5, 64'hABCD);
    wait_tag();
    check("s28_tag_latency", 128'(tag_vis_cyc), 128'(dig_hs_cyc + 1));
    check("s28_pkt_count", 128'(pkt_count), 128'(model_count));
    compare_streams("s28");

    // Hash side stalls for 5 cycles in the middle of a packet
    fill_random(4);
    send_pkt(6'd9, 2, 4);
    give_digest(64'h0123_4567_89AB_CDEF, 3);
    expect_tag(6'd9, 64'h0123_4567_89AB_CDEF);
    wait_tag();
    compare_streams("s29");

    // Digest offered early is held off until the first wait cycle
    d = {$urandom, $urandom};
    s_dig_tvalid = 1'b1; s_dig_tdata = d;
    #1;
    check("s31_dig_ready_payload", 128'(s_dig_tready), 128'(0));
    fill_random(2);
    send_pkt(6'd33, -1, 2);
    check("s31_no_early_dig", 128'(dig_hs_cnt), 128'(2));
    begin
      int unsigned start;
      int          budget;
      start = dig_hs_cnt; budget = 0;
      while (dig_hs_cnt == start && budget < 20) begin tick(); budget++; end
    end
    s_dig_tvalid = 1'b0;
    check("s31_dig_first_wait", 128'(dig_hs_cyc), 128'(last_pay_cyc + 1));
    expect_tag(6'd33, d);
    wait_tag();
    compare_streams("s31");

    // Randomized packets with random backpressure on both outputs
    rand_bp = 1'b1;
    for (int p = 0; p < 8; p++) begin
      fill_random(int'($urandom_range(1, 5)));
      id = IW'($urandom);
      d  = {$urandom, $urandom};
      send_pkt(id, -1, pkt_data.size());
      give_digest(d, $urandom_range(0, 12));
      expect_tag(id, d);
      wait_tag();
      check("rand_pkt_count", 128'(pkt_count), 128'(model_count));
    end
    rand_bp = 1'b0;
    m_axis_tready = 1'b1; m_hash_tready = 1'b1;
    tick();
    compare_streams("rand");
    check("rand_timeout_err", 128'(timeout_err), 128'(0));

    // Digest on the last permitted wait cycle wins over the timeout
    fill_random(1);
    d = {$urandom, $urandom};
    tag_vis_seen = 1'b0;
    send_pkt(6'd17, -1, 1);
    give_digest(d, TO - 1);
    check("tie_dig_cycle", 128'(dig_hs_cyc), 128'(last_pay_cyc + TO));
    expect_tag(6'd17, d);
    wait_tag();
    check("tie_tag_latency", 128'(tag_vis_cyc), 128'(dig_hs_cyc + 1));
    check("tie_timeout_err", 128'(timeout_err), 128'(0));
    compare_streams("tie");

    // Tag held under alternating backpressure while pkt_count wraps
    dut.r_pkt_count <= 32'hFFFF_FFFF;
    model_count = 32'hFFFF_FFFF;
    tick();
    check("wrap_preset", 128'(pkt_count), 128'(model_count));
    fill_random(2);
    d = {$urandom, $urandom};
    send_pkt(6'd42, -1, 2);
    m_axis_tready = 1'b0;
    give_digest(d, 2);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_axis_tready = (i % 2 == 1);
      #1;
      if (i < 2) begin
        check("wrap_tag_valid", 128'(m_axis_tvalid && m_axis_tlast), 128'(1));
        check("wrap_tag_data", 128'(m_axis_tdata), 128'(d));
        check("wrap_tag_id", 128'(m_axis_tid), 128'(6'd42));
      end
      tick();
    end
    m_axis_tready = 1'b1;
    expect_tag(6'd42, d);
    check("wrap_pkt_count", 128'(pkt_count), 128'(model_count));
    check("wrap_zero", 128'(model_count), 128'(0));
    compare_streams("wrap");

    // Digest never returned: all-zero tag TO cycles after the last payload edge
    fill_random(2);
    tag_vis_seen = 1'b0;
    send_pkt(6'd7, -1, 2);
    expect_tag(6'd7, '0);
    wait_tag();
    // last_pay_cyc is sampled the cycle before its edge; tag becomes visible TO edges after it
    check("to_tag_cycle", 128'(tag_vis_cyc), 128'(last_pay_cyc + 1 + TO));
    check("to_err_set", 128'(timeout_err), 128'(1));
    fill_random(1);
    send_pkt(6'd8, -1, 1);
    give_digest(64'h5A5A, 1);
    expect_tag(6'd8, 64'h5A5A);
    wait_tag();
    check("to_err_sticky", 128'(timeout_err), 128'(1));
    compare_streams("to");

    // Reset after beat 2 of a 4-beat packet abandons it
    fill_random(4);
    send_pkt(6'd3, -1, 2);
    areset = 1'b1;
    #1;
    check("midrst_net_valid", 128'(m_axis_tvalid), 128'(0));
    check("midrst_hash_valid", 128'(m_hash_tvalid), 128'(0));
    check("midrst_s_ready", 128'(s_axis_tready), 128'(0));
    tick(); tick();
    areset = 1'b0;
    model_count = 32'd0;
    begin
      int unsigned tags_before;
      tags_before = tag_cnt;
      repeat (TO + 8) tick();
      check("midrst_no_tag", 128'(tag_cnt), 128'(tags_before));
    end
    check("midrst_pkt_count", 128'(pkt_count), 128'(0));
    check("midrst_err_clear", 128'(timeout_err), 128'(0));
    check("midrst_dig_ready", 128'(s_dig_tready), 128'(0));
    compare_streams("midrst");
    fill_random(1);
    d = {$urandom, $urandom};
    send_pkt(6'd21, -1, 1);
    give_digest(d, 4);
    expect_tag(6'd21, d);
    wait_tag();
    check("after_rst_pkt_count", 128'(pkt_count), 128'(model_count));
    compare_streams("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hmac_tag_append
